output_queue_tx: RTL and testbench

//  Transmit end of a switch port: pops one 32-bit dest-IP metadata word and the matching

---
 rtl/output_queue_pkg.sv | 17 +
 rtl/axis_pipe_reg.sv | 52 +++++
 rtl/output_queue_tx.sv | 164 ++++++++++++++++
 tb/tb_output_queue_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_queue_pkg.sv
// Shared types and constants for the output-queue transmit path.
// The input side uses the same default packet-length limit.
package output_queue_pkg;

    localparam int unsigned DEFAULT_MAX_PKT_BYTES = 510;
    localparam int unsigned IP_W                  = 32;
    localparam int unsigned BYTE_W                = 8;

    typedef enum logic [2:0] {
        IDLE,
        FORWARD,
        DRAIN,
        WAIT_EMPTY,
        GAP
    } tx_state_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage registered AXI-Stream slice carrying data and last.
// Accepts a new beat whenever the stage is empty or is being drained in the same cycle.
module axis_pipe_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        in_ready_o = ~valid_q | out_ready_i;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
                last_d = in_last_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/output_queue_tx.sv
// Switch-port transmit engine: pairs a metadata word with its byte stream, truncates
// over-long packets, enforces the inter-packet gap. Optional IP filter: OUTPUT_QUEUE_IPFILTER_EN.
module output_queue_tx
    import output_queue_pkg::*;
#(
    parameter int unsigned MAX_PKT_BYTES = DEFAULT_MAX_PKT_BYTES,
    parameter int unsigned IFG_CYCLES    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              meta_axis_tvalid,
    input  logic [IP_W-1:0]   meta_axis_tdata,
    output logic              meta_axis_tready,
    input  logic              buf_axis_tvalid,
    input  logic [BYTE_W-1:0] buf_axis_tdata,
    input  logic              buf_axis_tlast,
    output logic              buf_axis_tready,
    output logic              pmod_axis_tvalid,
    output logic [BYTE_W-1:0] pmod_axis_tdata,
    output logic              pmod_axis_tlast,
    input  logic              pmod_axis_tready,
    input  logic [IP_W-1:0]   filter_ip,
    input  logic [IP_W-1:0]   filter_mask,
    output logic              tx_busy,
    output logic [31:0]       packet_sent_count,
    output logic [31:0]       packet_dropped_count
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_BYTES + 1);
    localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(IFG_CYCLES);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [IP_W-1:0]  dest_ip_q, dest_ip_d;
    logic             drop_q, drop_d;
    logic             meta_rdy_q, meta_rdy_d;
    logic [31:0]      sent_q, sent_d;
    logic [31:0]      dropped_q, dropped_d;

    logic pipe_in_valid, pipe_in_last, pipe_in_ready;
    logic meta_hs, buf_hs, at_limit, filtered;

`ifdef OUTPUT_QUEUE_IPFILTER_EN
    assign filtered = (meta_axis_tdata & filter_mask) != (filter_ip & filter_mask);
`else
    logic unused_filter;
    assign filtered      = 1'b0;
    assign unused_filter = ^{filter_ip, filter_mask};
`endif

    // dest_ip is held for downstream use but not consumed inside this block
    logic unused_dest;
    assign unused_dest = ^dest_ip_q;

    assign meta_axis_tready = meta_rdy_q;
    assign meta_hs          = meta_axis_tvalid & meta_rdy_q;
    assign buf_axis_tready  = ((state_q == FORWARD) & pipe_in_ready) | (state_q == DRAIN);
    assign buf_hs           = buf_axis_tvalid & buf_axis_tready;
    assign pipe_in_valid    = (state_q == FORWARD) & buf_axis_tvalid;
    assign at_limit         = byte_cnt_q == LAST_IDX;
    assign pipe_in_last     = buf_axis_tlast | at_limit;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        dest_ip_d  = dest_ip_q;
        drop_d     = drop_q;
        dropped_d  = dropped_q;
        sent_d     = sent_q;
        if (pmod_axis_tvalid && pmod_axis_tready && pmod_axis_tlast) begin
            sent_d = sent_q + 32'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (meta_hs) begin
                    dest_ip_d  = meta_axis_tdata;
                    byte_cnt_d = '0;
                    drop_d     = filtered;
                    state_d    = filtered ? DRAIN : FORWARD;
                end
            end
            FORWARD: begin
                if (buf_hs) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (buf_axis_tlast) begin
                        state_d = WAIT_EMPTY;
                    end else if (at_limit) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (buf_hs && buf_axis_tlast) begin
                    state_d = WAIT_EMPTY;
                    if (drop_q) begin
                        dropped_d = dropped_q + 32'd1;
                    end
                end
            end
            WAIT_EMPTY: begin
                // Leave as soon as the register is guaranteed empty next cycle
                if (!pmod_axis_tvalid || pmod_axis_tready) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        meta_rdy_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            dest_ip_q  <= '0;
            drop_q     <= 1'b0;
            meta_rdy_q <= 1'b0;
            sent_q     <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            dest_ip_q  <= dest_ip_d;
            drop_q     <= drop_d;
            meta_rdy_q <= meta_rdy_d;
            sent_q     <= sent_d;
            dropped_q  <= dropped_d;
        end
    end

    axis_pipe_reg #(
        .DATA_W(BYTE_W)
    ) u_out_reg (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .in_valid_i (pipe_in_valid),
        .in_data_i  (buf_axis_tdata),
        .in_last_i  (pipe_in_last),
        .in_ready_o (pipe_in_ready),
        .out_valid_o(pmod_axis_tvalid),
        .out_data_o (pmod_axis_tdata),
        .out_last_o (pmod_axis_tlast),
        .out_ready_i(pmod_axis_tready)
    );

    assign tx_busy              = state_q != IDLE;
    assign packet_sent_count    = sent_q;
    assign packet_dropped_count = dropped_q;

endmodule

// File: tb/tb_output_queue_tx.sv
// Scoreboard bench for output_queue_tx: stimulus pushes expected beats, a negedge
// monitor pops and compares every pmod handshake.
module tb_output_queue_tx;

    localparam int MAX_BYTES = 510;
    localparam int TIMEOUT   = 3000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        meta_axis_tvalid;
    logic [31:0] meta_axis_tdata;
    logic        meta_axis_tready;
    logic        buf_axis_tvalid;
    logic [7:0]  buf_axis_tdata;
    logic        buf_axis_tlast;
    logic        buf_axis_tready;
    logic        pmod_axis_tvalid;
    logic [7:0]  pmod_axis_tdata;
    logic        pmod_axis_tlast;
    logic        pmod_axis_tready = 1'b1;
    logic [31:0] filter_ip;
    logic [31:0] filter_mask;
    logic        tx_busy;
    logic [31:0] packet_sent_count;
    logic [31:0] packet_dropped_count;

    output_queue_tx dut (
        .clk                 (clk),
        .resetn              (resetn),
        .meta_axis_tvalid    (meta_axis_tvalid),
        .meta_axis_tdata     (meta_axis_tdata),
        .meta_axis_tready    (meta_axis_tready),
        .buf_axis_tvalid     (buf_axis_tvalid),
        .buf_axis_tdata      (buf_axis_tdata),
        .buf_axis_tlast      (buf_axis_tlast),
        .buf_axis_tready     (buf_axis_tready),
        .pmod_axis_tvalid    (pmod_axis_tvalid),
        .pmod_axis_tdata     (pmod_axis_tdata),
        .pmod_axis_tlast     (pmod_axis_tlast),
        .pmod_axis_tready    (pmod_axis_tready),
        .filter_ip           (filter_ip),
        .filter_mask         (filter_mask),
        .tx_busy             (tx_busy),
        .packet_sent_count   (packet_sent_count),
        .packet_dropped_count(packet_dropped_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [8:0]  sb[$];
    int unsigned exp_sent = 0;
    int unsigned exp_dropped = 0;
    bit          stall_mode = 1'b0;
    int          low_run = 0;
    bit          seen_valid = 1'b0;
    int          last_gap = -1;
    int          first_buf_cyc = -1;
    int          first_pmod_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        pmod_axis_tready = stall_mode ? ~pmod_axis_tready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Monitor: scoreboard pops, backpressure rule, gap and latency tracking
    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (resetn) begin
            if (pmod_axis_tvalid && pmod_axis_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=0x%0h required=none",
                             {pmod_axis_tlast, pmod_axis_tdata});
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat", {23'd0, pmod_axis_tlast, pmod_axis_tdata}, {23'd0, exp_beat});
                end
            end
            if (stall_mode && pmod_axis_tvalid && !pmod_axis_tready) begin
                check("stall_buf_tready", {31'd0, buf_axis_tready}, 32'd0);
            end
            if (pmod_axis_tvalid) begin
                if (seen_valid && low_run > 0) last_gap = low_run;
                low_run    = 0;
                seen_valid = 1'b1;
            end else begin
                low_run++;
            end
            if (first_buf_cyc < 0 && buf_axis_tvalid && buf_axis_tready) first_buf_cyc = cyc;
            if (first_pmod_cyc < 0 && pmod_axis_tvalid) first_pmod_cyc = cyc;
        end
    end

    // All drive tasks are entered and left just after a rising edge
    task automatic send_meta(input logic [31:0] m);
        int n = 0;
        bit done = 1'b0;
        meta_axis_tvalid = 1'b1;
        meta_axis_tdata  = m;
        while (!done) begin
            @(negedge clk);
            if (meta_axis_tready) begin
                done = 1'b1;
            end else if (n >= TIMEOUT) begin
                timeout_fail("meta_handshake");
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        meta_axis_tvalid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit fwd, input logic el);
        int n = 0;
        bit done = 1'b0;
        buf_axis_tvalid = 1'b1;
        buf_axis_tdata  = d;
        buf_axis_tlast  = l;
        if (fwd) sb.push_back({el, d});
        while (!done) begin
            @(negedge clk);
            if (buf_axis_tready) begin
                done = 1'b1;
            end else if (n >= TIMEOUT) begin
                timeout_fail("buf_handshake");
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input int len, input logic [31:0] m, input logic [7:0] base,
                            input bit fwd);
        send_meta(m);
        for (int i = 0; i < len; i++) begin
            send_byte(base + 8'(i), i == len - 1, fwd && (i < MAX_BYTES),
                      (i == len - 1) || (i == MAX_BYTES - 1));
        end
        buf_axis_tvalid = 1'b0;
        buf_axis_tlast  = 1'b0;
        if (fwd) exp_sent++;
        else exp_dropped++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || pmod_axis_tvalid || sb.size() != 0) && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= TIMEOUT) timeout_fail("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn           = 1'b0;
        meta_axis_tvalid = 1'b0;
        meta_axis_tdata  = '0;
        buf_axis_tvalid  = 1'b0;
        buf_axis_tdata   = '0;
        buf_axis_tlast   = 1'b0;
        filter_ip        = '0;
        filter_mask      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pmod_tvalid", {31'd0, pmod_axis_tvalid}, 32'd0);
        check("rst_pmod_tdata", {24'd0, pmod_axis_tdata}, 32'd0);
        check("rst_pmod_tlast", {31'd0, pmod_axis_tlast}, 32'd0);
        check("rst_meta_tready", {31'd0, meta_axis_tready}, 32'd0);
        check("rst_buf_tready", {31'd0, buf_axis_tready}, 32'd0);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_sent", packet_sent_count, 32'd0);
        check("rst_dropped", packet_dropped_count, 32'd0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_meta_tready", {31'd0, meta_axis_tready}, 32'd1);

        // Data without metadata must wait
        buf_axis_tvalid = 1'b1;
        @(negedge clk);
        check("no_meta_buf_tready", {31'd0, buf_axis_tready}, 32'd0);
        @(posedge clk);
        #1;
        buf_axis_tvalid = 1'b0;

        // 64-byte packet, one-cycle pass-through latency
        first_buf_cyc  = -1;
        first_pmod_cyc = -1;
        send_pkt(64, 32'hC0A80102, 8'h00, 1'b1);
        wait_idle();
        check("t1_latency", 32'(first_pmod_cyc - first_buf_cyc), 32'd1);
        check("t1_sent", packet_sent_count, exp_sent);

        // Back-to-back packets: gap of IFG_CYCLES+3
        seen_valid = 1'b0;
        last_gap   = -1;
        send_pkt(20, 32'h0A000001, 8'h40, 1'b1);
        send_pkt(20, 32'h0A000002, 8'h80, 1'b1);
        wait_idle();
        check("t2_gap", 32'(last_gap), 32'd7);
        check("t2_sent", packet_sent_count, exp_sent);

        // Alternating downstream ready
        stall_mode = 1'b1;
        send_pkt(32, 32'h0A000003, 8'h10, 1'b1);
        wait_idle();
        stall_mode = 1'b0;
        check("t3_sent", packet_sent_count, exp_sent);

        // Over-long packet truncated, following packet intact
        send_pkt(600, 32'h0A000004, 8'h00, 1'b1);
        send_pkt(16, 32'h0A000005, 8'hA0, 1'b1);
        wait_idle();
        check("t4_sent", packet_sent_count, exp_sent);

        filter_ip   = 32'h0A000000;
        filter_mask = 32'hFF000000;
`ifdef OUTPUT_QUEUE_IPFILTER_EN
        send_pkt(8, 32'hC0A80001, 8'h55, 1'b0);
        wait_idle();
        check("t5_dropped", packet_dropped_count, exp_dropped);
        check("t5_sent_after_drop", packet_sent_count, exp_sent);
        send_pkt(8, 32'h0A010203, 8'h66, 1'b1);
        wait_idle();
        check("t5_sent", packet_sent_count, exp_sent);
`else
        send_pkt(8, 32'hC0A80001, 8'h55, 1'b1);
        wait_idle();
        check("t5_dropped", packet_dropped_count, 32'd0);
        check("t5_sent", packet_sent_count, exp_sent);
`endif

        // Reset in the middle of a 40-byte packet
        send_meta(32'h0A000006);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0);
        end
        resetn = 1'b0;
        #1;
        check("mid_rst_pmod_tvalid", {31'd0, pmod_axis_tvalid}, 32'd0);
        check("mid_rst_pmod_tdata", {24'd0, pmod_axis_tdata}, 32'd0);
        check("mid_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_sent", packet_sent_count, 32'd0);
        check("mid_rst_buf_tready", {31'd0, buf_axis_tready}, 32'd0);
        buf_axis_tvalid = 1'b0;
        sb.delete();
        exp_sent    = 0;
        exp_dropped = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(12, 32'h0A000007, 8'hE0, 1'b1);
        wait_idle();
        check("post_rst_sent", packet_sent_count, exp_sent);
        check("post_rst_dropped", packet_dropped_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
